// File: rtl/hash_job_scheduler.sv
// hash_job_scheduler: walks the RAM entries of a job, issues nonces to a hash core and reports per-entry hits or misses
//   clk, reset_L (async, active-high)    : clock and reset
//   start, abort                         : begin a job (IDLE only) / end a running job
//   num_entradas, target                 : entries minus one and difficulty threshold, sampled at start
//   rd_ptr                               : RAM entry currently being hashed
//   core_start, core_nonce               : launch pulse and nonce for the hash core
//   core_done, core_H                    : completion pulse and hash result from the core
//   res_valid, res_hit, res_idx,
//   res_nonce, res_bounty                : per-entry result, fields held until the next res_valid
//   busy, done                           : job in progress / one-cycle end-of-job pulse
module hash_job_scheduler #(
    parameter logic [31:0] NONCE_LIMIT = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  num_entradas,
    input  logic [7:0]  target,
    output logic [1:0]  rd_ptr,
    output logic        core_start,
    output logic [31:0] core_nonce,
    input  logic        core_done,
    input  logic [23:0] core_H,
    output logic        res_valid,
    output logic        res_hit,
    output logic [1:0]  res_idx,
    output logic [31:0] res_nonce,
    output logic [23:0] res_bounty,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, REPORT, DONE} state_t;
    state_t state, next;
    logic [1:0] last_idx;
    logic [7:0] tgt;
    logic       hit;
    logic       at_limit;
    assign hit      = core_H[23:16] < tgt;
    assign at_limit = core_nonce == NONCE_LIMIT;
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) state <= IDLE;
        else         state <= next;
    end
    always_comb begin
        next       = state;
        core_start = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;
        busy       = state != IDLE;
        case (state)
            IDLE:    next = start ? LOAD : IDLE;
            LOAD:    next = abort ? DONE : ISSUE;
            ISSUE: begin
                core_start = 1'b1;
                next       = abort ? DONE : WAIT;
            end
            // abort outranks a simultaneous core_done
            WAIT:    next = abort ? DONE : !core_done ? WAIT : (hit || at_limit) ? REPORT : ISSUE;
            // the result of this entry is still reported when abort lands here
            REPORT: begin
                res_valid = 1'b1;
                next      = (abort || rd_ptr == last_idx) ? DONE : LOAD;
            end
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
    // core_nonce doubles as the working nonce; it only advances while below the limit, so it never wraps
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            last_idx   <= '0;
            tgt        <= '0;
            rd_ptr     <= '0;
            core_nonce <= '0;
            res_hit    <= 1'b0;
            res_idx    <= '0;
            res_nonce  <= '0;
            res_bounty <= '0;
        end else if (state == IDLE && start) begin
            last_idx   <= num_entradas;
            tgt        <= target;
            rd_ptr     <= '0;
            core_nonce <= '0;
        end else if (state == WAIT && core_done && !abort) begin
            if (hit || at_limit) begin
                res_hit    <= hit;
                res_idx    <= rd_ptr;
                res_nonce  <= core_nonce;
                res_bounty <= core_H;
            end else begin
                core_nonce <= core_nonce + 32'd1;
            end
        end else if (state == REPORT && !abort && rd_ptr != last_idx) begin
            rd_ptr     <= rd_ptr + 2'd1;
            core_nonce <= '0;
        end
    end
endmodule

// File: tb/tb_hash_job_scheduler.sv
// tb_hash_job_scheduler: scoreboard bench for hash_job_scheduler (default limit and NONCE_LIMIT=3 instances)
module tb_hash_job_scheduler;
    typedef struct packed {
        logic        hit;
        logic [1:0]  idx;
        logic [31:0] nonce;
        logic [23:0] bounty;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_L = 1'b1;
    logic        start = 1'b0, abort = 1'b0, start_b = 1'b0;
    logic [1:0]  num_entradas = '0;
    logic [7:0]  target = '0;
    logic [1:0]  rd_ptr, res_idx, rd_ptr_b, res_idx_b;
    logic        core_start, core_done, res_valid, res_hit, busy, done;
    logic        core_start_b, core_done_b, res_valid_b, res_hit_b, busy_b, done_b;
    logic [31:0] core_nonce, res_nonce, core_nonce_b, res_nonce_b;
    logic [23:0] core_H, res_bounty, core_H_b, res_bounty_b;

    res_t exp_q[$], exp_qb[$];
    res_t e, eb;
    int errors = 0, checks = 0;
    int n_valid = 0, n_done = 0, n_fast = 0, n_issue_b = 0;
    logic [31:0] max_nonce_b = '0;

    logic [31:0] hit_nonce [4];
    logic [7:0]  hit_hb = 8'h05, miss_hb = 8'hFF;
    int          cnt = 0;
    logic [31:0] m_nonce;
    logic [1:0]  m_idx;
    time         done_t = 0;
    logic [31:0] b_hit_nonce = 32'hFFFF_FFFF;
    logic [7:0]  b_hit_hb = 8'h05, b_miss_hb = 8'hFF;
    int          cnt_b = 0;
    logic [31:0] m_nonce_b;

    always #5 clk = ~clk;

    hash_job_scheduler dut (
        .clk(clk), .reset_L(reset_L), .start(start), .abort(abort),
        .num_entradas(num_entradas), .target(target), .rd_ptr(rd_ptr),
        .core_start(core_start), .core_nonce(core_nonce), .core_done(core_done), .core_H(core_H),
        .res_valid(res_valid), .res_hit(res_hit), .res_idx(res_idx), .res_nonce(res_nonce),
        .res_bounty(res_bounty), .busy(busy), .done(done)
    );

    hash_job_scheduler #(.NONCE_LIMIT(32'd3)) dut_b (
        .clk(clk), .reset_L(reset_L), .start(start_b), .abort(abort),
        .num_entradas(num_entradas), .target(target), .rd_ptr(rd_ptr_b),
        .core_start(core_start_b), .core_nonce(core_nonce_b), .core_done(core_done_b), .core_H(core_H_b),
        .res_valid(res_valid_b), .res_hit(res_hit_b), .res_idx(res_idx_b), .res_nonce(res_nonce_b),
        .res_bounty(res_bounty_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [23:0] bounty_a(input logic [7:0] hb, input logic [1:0] idx, input logic [31:0] n);
        return {hb, 6'h28, idx, n[7:0]};
    endfunction

    function automatic res_t mk(input logic hit, input logic [1:0] idx, input logic [31:0] n, input logic [23:0] h);
        return {hit, idx, n, h};
    endfunction

    // hash core models: answer two cycles after core_start
    initial begin
        core_done = 1'b0;
        core_H = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_H = bounty_a((m_nonce == hit_nonce[m_idx]) ? hit_hb : miss_hb, m_idx, m_nonce);
                    done_t = $time;
                end
            end else if (core_start) begin
                cnt = 2;
                m_nonce = core_nonce;
                m_idx = rd_ptr;
            end
        end
    end

    initial begin
        core_done_b = 1'b0;
        core_H_b = '0;
        forever begin
            @(negedge clk);
            core_done_b = 1'b0;
            if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) begin
                    core_done_b = 1'b1;
                    core_H_b = {(m_nonce_b == b_hit_nonce) ? b_hit_hb : b_miss_hb, 8'hB0, m_nonce_b[7:0]};
                end
            end else if (core_start_b) begin
                cnt_b = 2;
                m_nonce_b = core_nonce_b;
            end
        end
    end

    // scoreboard monitors
    initial forever begin
        @(negedge clk);
        if (res_valid) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL res_a unexpected: hit=%0b idx=%0d nonce=%0h H=%0h, required no result", res_hit, res_idx, res_nonce, res_bounty);
            end else begin
                e = exp_q.pop_front();
                if ({res_hit, res_idx, res_nonce, res_bounty} !== e) begin
                    errors++;
                    $display("FAIL res_a: got hit=%0b idx=%0d nonce=%0h H=%0h, required hit=%0b idx=%0d nonce=%0h H=%0h",
                             res_hit, res_idx, res_nonce, res_bounty, e.hit, e.idx, e.nonce, e.bounty);
                end
            end
        end
        if (done) n_done++;
        if (core_start && ($time - done_t) == 10) n_fast++;
    end

    initial forever begin
        @(negedge clk);
        if (res_valid_b) begin
            checks++;
            if (exp_qb.size() == 0) begin
                errors++;
                $display("FAIL res_b unexpected: hit=%0b nonce=%0h H=%0h, required no result", res_hit_b, res_nonce_b, res_bounty_b);
            end else begin
                eb = exp_qb.pop_front();
                if ({res_hit_b, res_idx_b, res_nonce_b, res_bounty_b} !== eb) begin
                    errors++;
                    $display("FAIL res_b: got hit=%0b idx=%0d nonce=%0h H=%0h, required hit=%0b idx=%0d nonce=%0h H=%0h",
                             res_hit_b, res_idx_b, res_nonce_b, res_bounty_b, eb.hit, eb.idx, eb.nonce, eb.bounty);
                end
            end
        end
        if (core_start_b) begin
            n_issue_b++;
            if (core_nonce_b > max_nonce_b) max_nonce_b = core_nonce_b;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic test_reset;
        hit_nonce = '{32'd0, 32'd0, 32'd0, 32'd0};
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got %0b want 0", core_start); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        checks++; if ({rd_ptr, core_nonce} !== 34'd0) begin errors++; $display("FAIL reset_ptr_nonce got %0h/%0h want 0/0", rd_ptr, core_nonce); end
        checks++; if ({res_hit, res_idx, res_nonce, res_bounty} !== 59'd0) begin errors++; $display("FAIL reset_res got %0b/%0d/%0h/%0h want zeros", res_hit, res_idx, res_nonce, res_bounty); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %0b want 0", busy_b); end
        reset_L = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n0 = n_valid, d0 = n_done;
        num_entradas = 2'd0; target = 8'h10; hit_nonce[0] = 32'd0; hit_hb = 8'h05;
        exp_q.push_back(mk(1'b1, 2'd0, 32'd0, bounty_a(8'h05, 2'd0, 32'd0)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({busy, core_start} !== 2'b10) begin errors++; $display("FAIL single_lat1 busy/core_start got %b want 10", {busy, core_start}); end
        @(negedge clk);
        checks++; if ({core_start, core_nonce} !== 33'h1_0000_0000) begin errors++; $display("FAIL single_lat2 core_start/nonce got %0b/%0h want 1/0", core_start, core_nonce); end
        for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_timeout res_valid got %0b want 1", res_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %0b want 1", done); end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL single_idle done/busy got %b want 00", {done, busy}); end
        checks++; if (n_valid - n0 != 1 || n_done - d0 != 1) begin errors++; $display("FAIL single_counts valid/done got %0d/%0d want 1/1", n_valid - n0, n_done - d0); end
    endtask

    task automatic test_multi;
        int n0 = n_valid, d0 = n_done, f0 = n_fast;
        hit_nonce = '{32'd2, 32'd0, 32'd5, 32'd1};
        num_entradas = 2'd3; target = 8'h10;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 2'(i), hit_nonce[i], bounty_a(8'h05, 2'(i), hit_nonce[i])));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; num_entradas = 2'd0; target = 8'h00;
        for (int i = 0; i < 400 && !done; i++) begin
            start = (i % 9 == 4);
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multi_timeout done got %0b want 1", done); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multi_busy got %0b want 0", busy); end
        checks++; if (rd_ptr !== 2'd3) begin errors++; $display("FAIL multi_rd_ptr_held got %0d want 3", rd_ptr); end
        checks++; if (n_valid - n0 != 4 || n_done - d0 != 1) begin errors++; $display("FAIL multi_counts valid/done got %0d/%0d want 4/1", n_valid - n0, n_done - d0); end
        checks++; if (n_fast - f0 != 8) begin errors++; $display("FAIL multi_miss_latency one-cycle reissues got %0d want 8", n_fast - f0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL multi_queue left %0d want 0", exp_q.size()); end
    endtask

    task automatic test_abort;
        int n0 = n_valid, d0 = n_done;
        num_entradas = 2'd0; target = 8'h10; hit_nonce = '{32'd0, 32'd0, 32'd0, 32'd0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !core_start; i++) @(negedge clk);
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL abort_issue_timeout core_start got %0b want 1", core_start); end
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({done, busy, res_valid} !== 3'b110) begin errors++; $display("FAIL abort_same_cycle done/busy/res_valid got %b want 110", {done, busy, res_valid}); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || n_valid != n0 || n_done - d0 != 1) begin errors++; $display("FAIL abort_after busy/valid/done got %0b/%0d/%0d want 0/0/1", busy, n_valid - n0, n_done - d0); end
        exp_q.push_back(mk(1'b1, 2'd0, 32'd0, bounty_a(8'h05, 2'd0, 32'd0)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        checks++; if (done !== 1'b1 || n_valid - n0 != 1) begin errors++; $display("FAIL abort_restart done/valid got %0b/%0d want 1/1", done, n_valid - n0); end
        @(negedge clk);
        num_entradas = 2'd1;
        exp_q.push_back(mk(1'b1, 2'd0, 32'd0, bounty_a(8'h05, 2'd0, 32'd0)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (done !== 1'b1 || rd_ptr !== 2'd0) begin errors++; $display("FAIL abort_report done/rd_ptr got %0b/%0d want 1/0", done, rd_ptr); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || n_valid - n0 != 2 || exp_q.size() != 0) begin errors++; $display("FAIL abort_report_after busy/valid/queue got %0b/%0d/%0d want 0/2/0", busy, n_valid - n0, exp_q.size()); end
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_idle busy/done got %b want 00", {busy, done}); end
    endtask

    task automatic test_exhaust;
        int i0 = n_issue_b;
        num_entradas = 2'd0; target = 8'h10; b_hit_nonce = 32'hFFFF_FFFF; b_miss_hb = 8'hFF;
        max_nonce_b = '0;
        exp_qb.push_back(mk(1'b0, 2'd0, 32'd3, 24'hFFB003));
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 100 && !done_b; i++) @(negedge clk);
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL exhaust_timeout done_b got %0b want 1", done_b); end
        checks++; if (n_issue_b - i0 != 4 || max_nonce_b !== 32'd3) begin errors++; $display("FAIL exhaust_issues count/max got %0d/%0h want 4/3", n_issue_b - i0, max_nonce_b); end
        @(negedge clk);
    endtask

    task automatic test_boundaries;
        logic [7:0]  tgt_t [3] = '{8'h10, 8'h10, 8'h00};
        logic [7:0]  hb_t  [3] = '{8'h10, 8'h0F, 8'h00};
        logic [7:0]  mhb_t [3] = '{8'hFF, 8'hFF, 8'h00};
        logic        hit_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] n_t   [3] = '{32'd3, 32'd1, 32'd3};
        for (int k = 0; k < 3; k++) begin
            num_entradas = 2'd0; target = tgt_t[k];
            b_hit_nonce = 32'd1; b_hit_hb = hb_t[k]; b_miss_hb = mhb_t[k];
            exp_qb.push_back(mk(hit_t[k], 2'd0, n_t[k], {hit_t[k] ? hb_t[k] : mhb_t[k], 8'hB0, n_t[k][7:0]}));
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            for (int i = 0; i < 100 && !done_b; i++) @(negedge clk);
            checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL boundary_%0d_timeout done_b got %0b want 1", k, done_b); end
            @(negedge clk);
        end
        checks++; if (exp_qb.size() != 0) begin errors++; $display("FAIL boundary_queue left %0d want 0", exp_qb.size()); end
    endtask

    task automatic test_reset_mid;
        int d0;
        logic saw_busy = 1'b0;
        num_entradas = 2'd3; target = 8'h10; hit_nonce = '{32'd0, 32'd0, 32'd3, 32'd0};
        exp_q.push_back(mk(1'b1, 2'd0, 32'd0, bounty_a(8'h05, 2'd0, 32'd0)));
        exp_q.push_back(mk(1'b1, 2'd1, 32'd0, bounty_a(8'h05, 2'd1, 32'd0)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !(core_start && rd_ptr == 2'd2); i++) @(negedge clk);
        checks++; if (!(core_start && rd_ptr == 2'd2)) begin errors++; $display("FAIL rstmid_reach entry2 core_start/rd_ptr got %0b/%0d want 1/2", core_start, rd_ptr); end
        @(negedge clk);
        checks++; if ({busy, res_hit, res_idx} !== 4'b1101) begin errors++; $display("FAIL rstmid_pre busy/hit/idx got %b want 1101", {busy, res_hit, res_idx}); end
        d0 = n_done;
        #2 reset_L = 1'b1;
        #1;
        checks++; if ({busy, done, core_start, res_valid} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctrl busy/done/core_start/res_valid got %b want 0000", {busy, done, core_start, res_valid}); end
        checks++; if ({rd_ptr, core_nonce} !== 34'd0) begin errors++; $display("FAIL rstmid_ptr got %0d/%0h want 0/0", rd_ptr, core_nonce); end
        checks++; if ({res_hit, res_idx, res_nonce, res_bounty} !== 59'd0) begin errors++; $display("FAIL rstmid_res got %0b/%0d/%0h/%0h want zeros", res_hit, res_idx, res_nonce, res_bounty); end
        @(negedge clk);
        reset_L = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
        end
        checks++; if (saw_busy !== 1'b0 || n_done != d0 || exp_q.size() != 0) begin errors++; $display("FAIL rstmid_idle busy/done/queue got %0b/%0d/%0d want 0/0/0", saw_busy, n_done - d0, exp_q.size()); end
        num_entradas = 2'd0; hit_nonce[0] = 32'd0;
        exp_q.push_back(mk(1'b1, 2'd0, 32'd0, bounty_a(8'h05, 2'd0, 32'd0)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        checks++; if (done !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL rstmid_rerun done/queue got %0b/%0d want 1/0", done, exp_q.size()); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_abort();
        test_exhaust();
        test_boundaries();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hash_job_scheduler.md
HASH_JOB_SCHEDULER -- requirements
Module: hash_job_scheduler

Interface
REQ-001 Parameter NONCE_LIMIT, default 32'h0000_FFFF, last nonce tried per entry before it is reported as a miss.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_L  input  1  asynchronous, active-high reset; asserted = 1.
REQ-004 start  input  1  one-cycle request to begin a job; honoured only in IDLE.
REQ-005 abort  input  1  terminates a running job; takes effect on the next edge.
REQ-006 num_entradas  input  2  entries in job minus one (0 means 1 entry, 3 means 4 entries); sampled at start.
REQ-007 target  input  8  difficulty threshold; sampled at start.
REQ-008 rd_ptr  output  2  RAM entry index being hashed.
REQ-009 core_start  output  1  one-cycle pulse launching one hash on core_nonce.
REQ-010 core_nonce  output  32  nonce presented to the hash core; stable from core_start until core_done.
REQ-011 core_done  input  1  one-cycle pulse from the hash core; core_H is valid in the same cycle.
REQ-012 core_H  input  24  hash result.
REQ-013 res_valid  output  1  one-cycle pulse per finished entry.
REQ-014 res_hit  output  1  1 = valid nonce found; 0 = NONCE_LIMIT exhausted.
REQ-015 res_idx / res_nonce / res_bounty  output  2/32/24  entry index, nonce, and H for the reported result; held until the next res_valid.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the job ends, whether by completion or by abort.

Function
REQ-018 The FSM SHALL have these states: IDLE, LOAD, ISSUE, WAIT, REPORT, DONE.
REQ-019 IDLE with start=1 SHALL latch num_entradas and target, set rd_ptr=0 and nonce=0, then go to LOAD.
REQ-020 LOAD SHALL last exactly one cycle, covering the 1-cycle RAM read latency, then go to ISSUE.
REQ-021 ISSUE SHALL assert core_start for exactly one cycle with core_nonce equal to the current nonce, then go to WAIT.
REQ-022 WAIT SHALL hold until core_done=1; a hit is core_H[23:16] < latched target (unsigned).
REQ-023 On a hit, the block SHALL capture res_nonce=nonce, res_bounty=core_H, res_hit=1, res_idx=rd_ptr, then go to REPORT.
REQ-024 On a miss with nonce==NONCE_LIMIT, the block SHALL capture res_hit=0, res_nonce=NONCE_LIMIT, res_bounty=core_H, then go to REPORT.
REQ-025 On a miss with nonce<NONCE_LIMIT, the block SHALL set nonce=nonce+1 and go to ISSUE; the nonce increment SHALL never wrap.
REQ-026 REPORT SHALL pulse res_valid for one cycle.
REQ-027 From REPORT, if rd_ptr==latched num_entradas the FSM SHALL go to DONE; otherwise rd_ptr+1, nonce=0, and LOAD.
REQ-028 DONE SHALL pulse done for one cycle, then return to IDLE; rd_ptr SHALL hold its last value.
REQ-029 Latency from start to the first core_start SHALL be 2 cycles; from core_done to the next core_start on a miss, 1 cycle.
REQ-030 core_done outside WAIT SHALL be ignored.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 A change to num_entradas or target during a job SHALL have no effect.
REQ-033 abort in any busy state SHALL go to DONE with no res_valid for the current entry.
REQ-034 If abort and core_done arrive in the same cycle, abort SHALL win.
REQ-035 If abort arrives in REPORT, that res_valid still fires and the next state is DONE.
REQ-036 abort in IDLE SHALL be ignored.

Reset
REQ-037 While reset_L=1, all outputs and state SHALL be forced asynchronously to: state IDLE, rd_ptr=0, core_start=0, core_nonce=0, res_valid=0, res_hit=0, res_idx=0, res_nonce=0, res_bounty=0, busy=0, done=0.
REQ-038 Reset asserted mid-job SHALL discard the job; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-039 num_entradas=0, target=8'h10, core returns H=24'h05_xxxx on nonce 0 -> core_start 2 cycles after start; one res_valid with hit=1, idx=0, nonce=0; done pulses 1 cycle after REPORT.
REQ-040 num_entradas=3, core hits on nonce 2,0,5,1 for entries 0..3 -> four res_valid pulses with idx 0..3 in order, matching nonces, and a single done pulse.
REQ-041 NONCE_LIMIT=3, core always returns H=24'hFF_FFFF, target=8'h10 -> nonces 0..3 issued, then res_hit=0 with res_nonce=3; no nonce 4 is ever issued.
REQ-042 abort asserted in WAIT in the same cycle as core_done -> no res_valid, done pulses, busy falls; a second start runs normally.
REQ-043 reset_L pulsed during WAIT of entry 2 -> all outputs at reset values immediately (asynchronous); extra start pulses while busy never restart the job.
REQ-044 Hit-compare boundaries: H[23:16]==target counts as a miss; H[23:16]==target-1 counts as a hit; target=8'h00 never hits.
